// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback over one shared memory.
// Optional lui/auipc support is built when MC_CTRL_UTYPE_EN is defined.
module multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7_5,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_write,
  output logic               adr_src,
  output logic               ir_write,
  output logic               pc_write,
  output logic               reg_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         imm_src,
  output logic [3:0]         alu_control,
  output logic               illegal,
  output logic [STATE_W-1:0] dbg_state
);

  // state  | meaning
  // RST    | post-reset idle, all outputs low
  // FETCH  | read instr at PC, PC+4 -> PC
  // DECODE | branch/jal target -> ALUOut
  // MEMADR | rs1+imm -> ALUOut;  MEMRD/MEMWB load;  MEMWR store
  // EXR    | reg-reg ALU op;  EXI reg-imm ALU op;  ALUWB write rd
  // BR     | compare, conditional PC load;  JAL/JALR jump;  LINK rd=old PC+4
  // UTYPE  | lui/auipc;  TRAP illegal opcode, held until reset
  typedef enum logic [3:0] {
    S_RST    = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,  S_MEMWB = 4'd5,  S_MEMWR  = 4'd6,  S_EXR    = 4'd7,
    S_EXI    = 4'd8,  S_ALUWB = 4'd9,  S_BR     = 4'd10, S_JAL    = 4'd11,
    S_JALR   = 4'd12, S_LINK  = 4'd13, S_UTYPE  = 4'd14, S_TRAP   = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  state_t state_q, state_d;

  // allow_sub is low for immediates: addi has no subtract form
  function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic f7, input logic allow_sub);
    case (f3)
      3'b000:  alu_map = (allow_sub && f7) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_map = ALU_SLL;
      3'b010:  alu_map = ALU_SLT;
      3'b011:  alu_map = ALU_SLTU;
      3'b100:  alu_map = ALU_XOR;
      3'b101:  alu_map = f7 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_map = ALU_OR;
      default: alu_map = ALU_AND;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RST;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    imm_src     = IMM_I;
    alu_control = ALU_ADD;
    illegal     = 1'b0;

    case (state_q)
      S_RST: state_d = S_FETCH;

      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_STORE:          imm_src = IMM_S;
          OP_BR:             imm_src = IMM_B;
          OP_JAL:            imm_src = IMM_J;
          OP_LUI, OP_AUIPC:  imm_src = IMM_U;
          default:           imm_src = IMM_I;
        endcase
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXR;
          OP_I:              state_d = S_EXI;
          OP_BR:             state_d = (funct3 == 3'b010 || funct3 == 3'b011) ? S_TRAP : S_BR;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
`ifdef MC_CTRL_UTYPE_EN
          OP_LUI, OP_AUIPC:  state_d = S_UTYPE;
`endif
          default:           state_d = S_TRAP;
        endcase
      end

      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
        state_d   = (op == OP_STORE) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end

      S_EXR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_map(funct3, funct7_5, 1'b1);
        state_d     = S_ALUWB;
      end

      S_EXI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_map(funct3, funct7_5, 1'b0);
        state_d     = S_ALUWB;
      end

      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end

      S_BR: begin
        alu_src_a = 2'b10;
        case (funct3)
          3'b000:  begin alu_control = ALU_SUB;  pc_write = zero;  end
          3'b001:  begin alu_control = ALU_SUB;  pc_write = ~zero; end
          3'b100:  begin alu_control = ALU_SLT;  pc_write = ~zero; end
          3'b101:  begin alu_control = ALU_SLT;  pc_write = zero;  end
          3'b110:  begin alu_control = ALU_SLTU; pc_write = ~zero; end
          3'b111:  begin alu_control = ALU_SLTU; pc_write = zero;  end
          default: begin alu_control = ALU_SUB;  pc_write = 1'b0;  end
        endcase
        state_d = S_FETCH;
      end

      S_JAL: begin
        pc_write = 1'b1;
        state_d  = S_LINK;
      end

      S_JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
        state_d    = S_LINK;
      end

      S_LINK: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end

`ifdef MC_CTRL_UTYPE_EN
      S_UTYPE: begin
        alu_src_a = (op == OP_LUI) ? 2'b11 : 2'b01;
        alu_src_b = 2'b01;
        imm_src   = IMM_U;
        state_d   = S_ALUWB;
      end
`endif

      S_TRAP: illegal = 1'b1;

      default: state_d = S_TRAP;
    endcase
  end

  assign dbg_state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus reset/TRAP/U-type sequences.
// Expectations for lui follow MC_CTRL_UTYPE_EN.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5, zero, mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_control, dbg_state;

  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RR = 7'b0110011, RI = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111;
  localparam logic [6:0] LU = 7'b0110111, AU = 7'b0010111, BAD = 7'b1111111;

  always #5 clk = ~clk;

  multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .illegal(illegal), .dbg_state(dbg_state)
  );

  // {mem_req,mem_write,adr_src,ir_write,pc_write,reg_write,result_src,a,b,imm,alu,illegal,state}
  logic [23:0] act;
  assign act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, result_src,
                alu_src_a, alu_src_b, imm_src, alu_control, illegal, dbg_state};

  function automatic logic [23:0] pk(input logic mr, mw, as, irw, pcw, rw, input logic [1:0] rs, a, b,
                                     input logic [2:0] imm, input logic [3:0] alu, input logic ill,
                                     input logic [3:0] st);
    pk = {mr, mw, as, irw, pcw, rw, rs, a, b, imm, alu, ill, st};
  endfunction

  function automatic logic [23:0] w_fetch(input logic rdy);
    w_fetch = pk(1, 0, 0, rdy, rdy, 0, 2'b10, 2'b00, 2'b10, 3'b000, 4'h0, 0, 4'd1);
  endfunction
  function automatic logic [23:0] w_dec(input logic [2:0] imm);
    w_dec = pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 4'h0, 0, 4'd2);
  endfunction
  function automatic logic [23:0] w_exr(input logic [3:0] alu);
    w_exr = pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, alu, 0, 4'd7);
  endfunction
  function automatic logic [23:0] w_exi(input logic [3:0] alu);
    w_exi = pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, alu, 0, 4'd8);
  endfunction
  function automatic logic [23:0] w_br(input logic [3:0] alu, input logic pcw);
    w_br = pk(0, 0, 0, 0, pcw, 0, 2'b00, 2'b10, 2'b00, 3'b000, alu, 0, 4'd10);
  endfunction

  localparam logic [23:0] W_ZERO  = 24'h0;
  localparam logic [23:0] W_ALUWB = {3'b000, 3'b001, 18'h0} | 24'd9;
  localparam logic [23:0] W_TRAP  = 24'h00001F;
  localparam logic [23:0] W_LINK  = {6'b000001, 2'b10, 2'b01, 2'b10, 3'b000, 4'h0, 1'b0, 4'd13};
  localparam logic [23:0] W_MEMRD = {6'b101000, 13'h0, 1'b0, 4'd4};

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7, z, rdy;
    logic [23:0] exp;
    string       tag;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic [6:0] o, input logic [2:0] f3, input logic f7, z, rdy,
                     input logic [23:0] e, input string tag);
    vec_t v;
    v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.rdy = rdy; v.exp = e; v.tag = tag;
    vecs.push_back(v);
  endtask

  task automatic chk(input logic [23:0] e, input string tag);
    n_vec++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, e);
    end
  endtask

  // Drive one cycle's inputs, compare at the falling edge, then advance past the rising edge
  task automatic step(input logic [6:0] o, input logic [2:0] f3, input logic f7, z, rdy,
                      input logic [23:0] e, input string tag);
    op = o; funct3 = f3; funct7_5 = f7; zero = z; mem_ready = rdy;
    @(negedge clk);
    chk(e, tag);
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in FETCH, one time unit after the rising edge
  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk(W_ZERO, {tag, "_assert"});
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1 chk(W_ZERO, {tag, "_rst_state"});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; op = RR; funct3 = 3'b000; funct7_5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;

    add(RR, 3'b000, 0, 0, 0, w_fetch(0), "add_fetch_wait1");
    add(RR, 3'b000, 0, 0, 0, w_fetch(0), "add_fetch_wait2");
    add(RR, 3'b000, 0, 0, 0, w_fetch(0), "add_fetch_wait3");
    add(RR, 3'b000, 0, 0, 1, w_fetch(1), "add_fetch_go");
    add(RR, 3'b000, 0, 0, 1, w_dec(3'b000), "add_decode");
    add(RR, 3'b000, 0, 0, 1, w_exr(4'b0000), "add_exr");
    add(RR, 3'b000, 0, 0, 1, W_ALUWB, "add_aluwb");
    add(RR, 3'b000, 1, 0, 1, w_fetch(1), "sub_fetch");
    add(RR, 3'b000, 1, 0, 1, w_dec(3'b000), "sub_decode");
    add(RR, 3'b000, 1, 0, 1, w_exr(4'b0001), "sub_exr");
    add(RR, 3'b000, 1, 0, 1, W_ALUWB, "sub_aluwb");
    add(RR, 3'b111, 0, 0, 1, w_fetch(1), "and_fetch");
    add(RR, 3'b111, 0, 0, 1, w_dec(3'b000), "and_decode");
    add(RR, 3'b111, 0, 0, 1, w_exr(4'b0010), "and_exr");
    add(RR, 3'b111, 0, 0, 1, W_ALUWB, "and_aluwb");
    add(RI, 3'b101, 1, 0, 1, w_fetch(1), "srai_fetch");
    add(RI, 3'b101, 1, 0, 1, w_dec(3'b000), "srai_decode");
    add(RI, 3'b101, 1, 0, 1, w_exi(4'b1001), "srai_exi");
    add(RI, 3'b101, 1, 0, 1, W_ALUWB, "srai_aluwb");
    add(RI, 3'b000, 1, 0, 1, w_fetch(1), "addi_f7_fetch");
    add(RI, 3'b000, 1, 0, 1, w_dec(3'b000), "addi_f7_decode");
    add(RI, 3'b000, 1, 0, 1, w_exi(4'b0000), "addi_f7_exi");
    add(RI, 3'b000, 1, 0, 1, W_ALUWB, "addi_f7_aluwb");
    add(BR, 3'b001, 0, 1, 1, w_fetch(1), "bne_z1_fetch");
    add(BR, 3'b001, 0, 1, 1, w_dec(3'b010), "bne_z1_decode");
    add(BR, 3'b001, 0, 1, 1, w_br(4'b0001, 0), "bne_z1_br");
    add(BR, 3'b001, 0, 0, 1, w_fetch(1), "bne_z0_fetch");
    add(BR, 3'b001, 0, 0, 1, w_dec(3'b010), "bne_z0_decode");
    add(BR, 3'b001, 0, 0, 1, w_br(4'b0001, 1), "bne_z0_br");
    add(BR, 3'b110, 0, 0, 1, w_fetch(1), "bltu_fetch");
    add(BR, 3'b110, 0, 0, 1, w_dec(3'b010), "bltu_decode");
    add(BR, 3'b110, 0, 0, 1, w_br(4'b0110, 1), "bltu_br");
    add(BR, 3'b101, 0, 1, 1, w_fetch(1), "bge_fetch");
    add(BR, 3'b101, 0, 1, 1, w_dec(3'b010), "bge_decode");
    add(BR, 3'b101, 0, 1, 1, w_br(4'b0101, 1), "bge_br");
    add(BR, 3'b000, 0, 0, 1, w_fetch(1), "beq_fetch");
    add(BR, 3'b000, 0, 0, 1, w_dec(3'b010), "beq_decode");
    add(BR, 3'b000, 0, 0, 1, w_br(4'b0001, 0), "beq_br");
    add(JL, 3'b000, 0, 0, 1, w_fetch(1), "jal_fetch");
    add(JL, 3'b000, 0, 0, 1, w_dec(3'b011), "jal_decode");
    add(JL, 3'b000, 0, 0, 1, pk(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0, 0, 4'd11), "jal_jal");
    add(JL, 3'b000, 0, 0, 1, W_LINK, "jal_link");
    add(JR, 3'b000, 0, 0, 1, w_fetch(1), "jalr_fetch");
    add(JR, 3'b000, 0, 0, 1, w_dec(3'b000), "jalr_decode");
    add(JR, 3'b000, 0, 0, 1, pk(0, 0, 0, 0, 1, 0, 2'b10, 2'b10, 2'b01, 3'b000, 4'h0, 0, 4'd12), "jalr_jalr");
    add(JR, 3'b000, 0, 0, 1, W_LINK, "jalr_link");
    add(LD, 3'b010, 0, 0, 1, w_fetch(1), "lw_fetch");
    add(LD, 3'b010, 0, 0, 1, w_dec(3'b000), "lw_decode");
    add(LD, 3'b010, 0, 0, 1, pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 4'h0, 0, 4'd3), "lw_memadr");
    add(LD, 3'b010, 0, 0, 0, W_MEMRD, "lw_memrd_wait");
    add(LD, 3'b010, 0, 0, 1, W_MEMRD, "lw_memrd_go");
    add(LD, 3'b010, 0, 0, 1, pk(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 4'h0, 0, 4'd5), "lw_memwb");
    add(ST, 3'b010, 0, 0, 1, w_fetch(1), "sw_fetch");
    add(ST, 3'b010, 0, 0, 1, w_dec(3'b001), "sw_decode");
    add(ST, 3'b010, 0, 0, 1, pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 4'h0, 0, 4'd3), "sw_memadr");
    add(ST, 3'b010, 0, 0, 0, pk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0, 0, 4'd6), "sw_memwr_wait");
    add(ST, 3'b010, 0, 0, 1, pk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0, 0, 4'd6), "sw_memwr_go");
    add(BR, 3'b010, 0, 0, 1, w_fetch(1), "br010_fetch");
    add(BR, 3'b010, 0, 0, 1, w_dec(3'b010), "br010_decode");
    add(BR, 3'b010, 0, 0, 1, W_TRAP, "br010_trap");
    add(RR, 3'b000, 0, 0, 1, W_TRAP, "trap_held");

    #1;
    apply_reset("init");
    foreach (vecs[i]) step(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, vecs[i].rdy, vecs[i].exp, vecs[i].tag);

    apply_reset("bad_rst");
    step(BAD, 3'b000, 0, 0, 1, w_fetch(1), "bad_fetch");
    step(BAD, 3'b000, 0, 0, 1, w_dec(3'b000), "bad_decode");
    step(BAD, 3'b000, 0, 0, 1, W_TRAP, "bad_trap");

    apply_reset("lui_rst");
    step(LU, 3'b000, 0, 0, 1, w_fetch(1), "lui_fetch");
    step(LU, 3'b000, 0, 0, 1, w_dec(3'b100), "lui_decode");
`ifdef MC_CTRL_UTYPE_EN
    step(LU, 3'b000, 0, 0, 1, pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 3'b100, 4'h0, 0, 4'd14), "lui_utype");
    step(LU, 3'b000, 0, 0, 1, W_ALUWB, "lui_aluwb");
    step(AU, 3'b000, 0, 0, 1, w_fetch(1), "auipc_fetch");
    step(AU, 3'b000, 0, 0, 1, w_dec(3'b100), "auipc_decode");
    step(AU, 3'b000, 0, 0, 1, pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b100, 4'h0, 0, 4'd14), "auipc_utype");
    step(AU, 3'b000, 0, 0, 1, W_ALUWB, "auipc_aluwb");
`else
    step(LU, 3'b000, 0, 0, 1, W_TRAP, "lui_trap");
`endif

    // Reset dropped while a load waits on memory
    apply_reset("mid_rst");
    step(LD, 3'b010, 0, 0, 1, w_fetch(1), "mid_fetch");
    step(LD, 3'b010, 0, 0, 1, w_dec(3'b000), "mid_decode");
    step(LD, 3'b010, 0, 0, 1, pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 4'h0, 0, 4'd3), "mid_memadr");
    op = LD; funct3 = 3'b010; mem_ready = 1'b0;
    @(negedge clk);
    chk(W_MEMRD, "mid_memrd");
    #2 rst_n = 1'b0;
    #1 chk(W_ZERO, "mid_abort");
    mem_ready = 1'b1;
    @(posedge clk);
    #1 chk(W_ZERO, "mid_held");
    rst_n = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk(W_ZERO, "mid_release");
    @(posedge clk);
    #1 chk(w_fetch(0), "mid_fetch_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
